// File: rtl/instr_sequencer_if.sv
// Bus between the instruction sequencer, the board loader/switches and the processor.
// The master side is the sequencer; the slave side is the loader/processor environment.
interface instr_sequencer_if #(
  parameter int AW = 4
);
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [15:0]   load_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          done;
  logic [15:0]   INSTRin;
  logic          run;
  logic          busy;
  logic          finished;
  logic          error;
  logic [AW-1:0] pc;
  logic [AW:0]   count;

  modport master (
    input  load_en, load_addr, load_data, prog_len, start, done,
    output INSTRin, run, busy, finished, error, pc, count
  );

  modport slave (
    output load_en, load_addr, load_data, prog_len, start, done,
    input  INSTRin, run, busy, finished, error, pc, count
  );
endinterface

// File: rtl/instr_sequencer.sv
// Issues a loaded program one instruction at a time to the mv/add/sub/mult processor,
// holding each word until done, with progress count and a per-instruction watchdog.
module instr_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  instr_sequencer_if.master bus
);
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [AW:0]   count_q;
  logic [AW:0]   len_q;
  logic [WW-1:0] wdog_q;
  logic          error_q;
  logic          run_q;
  logic          busy_q;
  logic          finished_q;
  logic [15:0]   slot_word [DEPTH];
  logic [AW:0]   len_d;
  logic          last_d;

  // Each slot is its own register so the whole buffer clears on reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [15:0] word_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          word_q <= 16'h0000;
        end else if (bus.load_en && (state_q == S_IDLE) && (bus.load_addr == AW'(gi))) begin
          word_q <= bus.load_data;
        end
      end
      assign slot_word[gi] = word_q;
    end
  endgenerate

  assign len_d  = (bus.prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.prog_len;
  assign last_d = ({1'b0, pc_q} == (len_q - 1'b1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      count_q    <= '0;
      len_q      <= '0;
      wdog_q     <= '0;
      error_q    <= 1'b0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      run_q      <= 1'b0;
      finished_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            error_q <= 1'b0;
            pc_q    <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            if (bus.prog_len != '0) begin
              len_q   <= len_d;
              run_q   <= 1'b1;
              state_q <= S_ISSUE;
            end else begin
              finished_q <= 1'b1;
              state_q    <= S_FINISH;
            end
          end
        end
        S_ISSUE: begin
          wdog_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          wdog_q <= wdog_q + 1'b1;
          // done takes priority over an expiring watchdog
          if (bus.done) begin
            count_q <= count_q + 1'b1;
            if (last_d) begin
              finished_q <= 1'b1;
              state_q    <= S_FINISH;
            end else begin
              pc_q    <= pc_q + 1'b1;
              run_q   <= 1'b1;
              state_q <= S_ISSUE;
            end
          end else if (wdog_q == WW'(TIMEOUT - 1)) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.INSTRin  = slot_word[pc_q];
  assign bus.run      = run_q;
  assign bus.busy     = busy_q;
  assign bus.finished = finished_q;
  assign bus.error    = error_q;
  assign bus.pc       = pc_q;
  assign bus.count    = count_q;
endmodule
